// File: rtl/cmp_feeder.sv
// Loads a 24x64 bitmap from row memory, then serves columns and top/bottom-scan rows
// to the comparator ALU on request and captures its result.
module cmp_feeder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        mem_rd,
    output logic [5:0]  mem_addr,
    input  logic [23:0] mem_data,
    output logic        alustart,
    output logic [63:0] bitcolumn,
    output logic        nextcolumnready,
    output logic [23:0] bitrowtop,
    output logic        nextrowtopready,
    output logic [23:0] bitrowbot,
    output logic        nextrowbotready,
    input  logic        nextcolumn,
    input  logic        nextrowtop,
    input  logic        nextrowbot,
    input  logic        cmpdone,
    input  logic [15:0] cmpresult,
    output logic [15:0] result,
    output logic        done,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StLoad, StClear, StServe, StFinish} state_e;

    state_e      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        rd_pend_q, rd_pend_d;
    logic [5:0]  pend_addr_q, pend_addr_d;
    logic [23:0] rows_q [64];
    logic [4:0]  col_q, col_d;
    logic [5:0]  top_q, top_d, bot_q, bot_d;
    logic [63:0] bitcolumn_q, bitcolumn_d;
    logic [23:0] bitrowtop_q, bitrowtop_d, bitrowbot_q, bitrowbot_d;
    logic        col_rdy_q, col_rdy_d, top_rdy_q, top_rdy_d, bot_rdy_q, bot_rdy_d;
    logic [15:0] result_q, result_d;
    logic        col_upd;
    logic [4:0]  bit_sel;
    logic [63:0] col_data;

    // Column c is bit (23-c) of every row, row 0 in bit 0.
    always_comb begin
        bit_sel = 5'd23 - col_d;
        for (int r = 0; r < 64; r++) begin
            col_data[r] = rows_q[r][bit_sel];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_pend_d   = 1'b0;
        pend_addr_d = pend_addr_q;
        col_d       = col_q;
        top_d       = top_q;
        bot_d       = bot_q;
        bitrowtop_d = bitrowtop_q;
        bitrowbot_d = bitrowbot_q;
        col_rdy_d   = 1'b0;
        top_rdy_d   = 1'b0;
        bot_rdy_d   = 1'b0;
        result_d    = result_q;
        col_upd     = 1'b0;
        mem_rd      = 1'b0;
        mem_addr    = 6'd0;
        alustart    = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    cnt_d   = 7'd0;
                end
            end
            StLoad: begin
                if (cnt_q < 7'd64) begin
                    mem_rd      = 1'b1;
                    mem_addr    = cnt_q[5:0];
                    rd_pend_d   = 1'b1;
                    pend_addr_d = cnt_q[5:0];
                    cnt_d       = cnt_q + 7'd1;
                end else begin
                    // Row 63 is written at the end of this cycle.
                    state_d = StClear;
                end
            end
            StClear: begin
                alustart    = 1'b1;
                state_d     = StServe;
                col_d       = 5'd0;
                top_d       = 6'd0;
                bot_d       = 6'd63;
                col_upd     = 1'b1;
                bitrowtop_d = rows_q[0];
                bitrowbot_d = rows_q[63];
                col_rdy_d   = 1'b1;
                top_rdy_d   = 1'b1;
                bot_rdy_d   = 1'b1;
            end
            StServe: begin
                if (cmpdone) begin
                    result_d = cmpresult;
                    state_d  = StFinish;
                end else begin
                    if (nextcolumn && col_q != 5'd23) begin
                        col_d     = col_q + 5'd1;
                        col_upd   = 1'b1;
                        col_rdy_d = 1'b1;
                    end
                    if (nextrowtop && top_q != 6'd63) begin
                        top_d       = top_q + 6'd1;
                        bitrowtop_d = rows_q[top_q + 6'd1];
                        top_rdy_d   = 1'b1;
                    end
                    if (nextrowbot && bot_q != 6'd0) begin
                        bot_d       = bot_q - 6'd1;
                        bitrowbot_d = rows_q[bot_q - 6'd1];
                        bot_rdy_d   = 1'b1;
                    end
                end
            end
            StFinish: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        bitcolumn_d = col_upd ? col_data : bitcolumn_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 7'd0;
            rd_pend_q   <= 1'b0;
            pend_addr_q <= 6'd0;
            col_q       <= 5'd0;
            top_q       <= 6'd0;
            bot_q       <= 6'd0;
            bitcolumn_q <= 64'd0;
            bitrowtop_q <= 24'd0;
            bitrowbot_q <= 24'd0;
            col_rdy_q   <= 1'b0;
            top_rdy_q   <= 1'b0;
            bot_rdy_q   <= 1'b0;
            result_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_pend_q   <= rd_pend_d;
            pend_addr_q <= pend_addr_d;
            col_q       <= col_d;
            top_q       <= top_d;
            bot_q       <= bot_d;
            bitcolumn_q <= bitcolumn_d;
            bitrowtop_q <= bitrowtop_d;
            bitrowbot_q <= bitrowbot_d;
            col_rdy_q   <= col_rdy_d;
            top_rdy_q   <= top_rdy_d;
            bot_rdy_q   <= bot_rdy_d;
            result_q    <= result_d;
        end
    end

    // Memory data arrives one cycle after its read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 64; r++) begin
                rows_q[r] <= 24'd0;
            end
        end else if (rd_pend_q) begin
            rows_q[pend_addr_q] <= mem_data;
        end
    end

    assign bitcolumn       = bitcolumn_q;
    assign nextcolumnready = col_rdy_q;
    assign bitrowtop       = bitrowtop_q;
    assign nextrowtopready = top_rdy_q;
    assign bitrowbot       = bitrowbot_q;
    assign nextrowbotready = bot_rdy_q;
    assign result          = result_q;
    assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_cmp_feeder.sv
// Bench for cmp_feeder: memory model, vector table, directed corner sequences and a
// randomized serve phase checked against an index-based reference model.
module tb_cmp_feeder;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        mem_rd;
    logic [5:0]  mem_addr;
    logic [23:0] mem_data = 24'd0;
    logic        alustart;
    logic [63:0] bitcolumn;
    logic        nextcolumnready;
    logic [23:0] bitrowtop, bitrowbot;
    logic        nextrowtopready, nextrowbotready;
    logic        nextcolumn, nextrowtop, nextrowbot;
    logic        cmpdone;
    logic [15:0] cmpresult;
    logic [15:0] result;
    logic        done, busy;

    cmp_feeder dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .mem_rd          (mem_rd),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .alustart        (alustart),
        .bitcolumn       (bitcolumn),
        .nextcolumnready (nextcolumnready),
        .bitrowtop       (bitrowtop),
        .nextrowtopready (nextrowtopready),
        .bitrowbot       (bitrowbot),
        .nextrowbotready (nextrowbotready),
        .nextcolumn      (nextcolumn),
        .nextrowtop      (nextrowtop),
        .nextrowbot      (nextrowbot),
        .cmpdone         (cmpdone),
        .cmpresult       (cmpresult),
        .result          (result),
        .done            (done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    logic [23:0] bm [64];

    always @(posedge clk) begin
        if (mem_rd) mem_data <= bm[mem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] col_of(input int c);
        logic [63:0] v;
        for (int r = 0; r < 64; r++) v[r] = bm[r][23 - c];
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic req(input logic nc, input logic nt, input logic nb);
        nextcolumn = nc;
        nextrowtop = nt;
        nextrowbot = nb;
        step();
        nextcolumn = 1'b0;
        nextrowtop = 1'b0;
        nextrowbot = 1'b0;
    endtask

    // Ends on the first SERVE cycle, before any request is driven.
    task automatic load_and_check();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk("load_rd", {63'd0, mem_rd}, 64'd1);
            chk("load_addr", {58'd0, mem_addr}, 64'(i));
            start = (i == 10);
            step();
        end
        start = 1'b0;
        chk("capture_rd_low", {63'd0, mem_rd}, 64'd0);
        chk("no_early_alustart", {63'd0, alustart}, 64'd0);
        step();
        chk("alustart", {63'd0, alustart}, 64'd1);
        chk("clear_no_ready", {61'd0, nextcolumnready, nextrowtopready, nextrowbotready}, 64'd0);
        step();
        chk("alustart_once", {63'd0, alustart}, 64'd0);
        chk("first_ready", {61'd0, nextcolumnready, nextrowtopready, nextrowbotready}, 64'd7);
        chk("first_col", bitcolumn, col_of(0));
        chk("first_top", {40'd0, bitrowtop}, {40'd0, bm[0]});
        chk("first_bot", {40'd0, bitrowbot}, {40'd0, bm[63]});
    endtask

    typedef struct {
        logic        nc, nt, nb;
        logic        cr, tr, br;
        logic [63:0] col;
        logic [23:0] top, bot;
    } vec_t;

    vec_t vt [5];
    int   mc, mt, mb;
    logic nc, nt, nb, ecr, etr, ebr;

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 24'h800000, 24'h800000};
        vt[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 24'h800000, 24'h800000};
        vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'd0, 24'h800000, 24'h800000};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'd0, 24'h800000, 24'h800000};
        vt[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 24'h800000, 24'h800000};

        rst = 1'b1; start = 1'b0; cmpdone = 1'b0; cmpresult = 16'd0;
        nextcolumn = 1'b0; nextrowtop = 1'b0; nextrowbot = 1'b0;
        repeat (3) step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_result", {48'd0, result}, 64'd0);
        chk("rst_col", bitcolumn, 64'd0);
        rst = 1'b0;
        step();
        chk("idle_rd", {63'd0, mem_rd}, 64'd0);

        // All rows 24'h800000: column 0 all ones, every other column zero.
        for (int r = 0; r < 64; r++) bm[r] = 24'h800000;
        load_and_check();
        chk("a_col0", bitcolumn, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int v = 0; v < 5; v++) begin
            req(vt[v].nc, vt[v].nt, vt[v].nb);
            chk("vec_ready", {61'd0, nextcolumnready, nextrowtopready, nextrowbotready},
                {61'd0, vt[v].cr, vt[v].tr, vt[v].br});
            chk("vec_col", bitcolumn, vt[v].col);
            chk("vec_top", {40'd0, bitrowtop}, {40'd0, vt[v].top});
            chk("vec_bot", {40'd0, bitrowbot}, {40'd0, vt[v].bot});
        end

        // Result capture; a request in the cmpdone cycle and a start in FINISH are ignored.
        cmpdone = 1'b1; cmpresult = 16'h1823; nextcolumn = 1'b1;
        step();
        cmpdone = 1'b0; nextcolumn = 1'b0;
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("result", {48'd0, result}, 64'h1823);
        chk("done_req_ignored", {63'd0, nextcolumnready}, 64'd0);
        chk("finish_busy", {63'd0, busy}, 64'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("done_once", {63'd0, done}, 64'd0);
        chk("idle_after_done", {63'd0, busy}, 64'd0);
        cmpdone = 1'b1; cmpresult = 16'hBEEF;
        step();
        cmpdone = 1'b0;
        chk("finish_start_ignored", {62'd0, busy, mem_rd}, 64'd0);
        chk("idle_cmpdone_ignored", {48'd0, result}, 64'h1823);

        // Row 5 = 24'h000001, rest zero.
        for (int r = 0; r < 64; r++) bm[r] = (r == 5) ? 24'h000001 : 24'h0;
        load_and_check();
        for (int k = 1; k <= 5; k++) begin
            req(1'b0, 1'b1, 1'b0);
            chk("top_ready", {63'd0, nextrowtopready}, 64'd1);
            chk("top_data", {40'd0, bitrowtop}, {40'd0, bm[k]});
            step();
            chk("top_pulse_end", {63'd0, nextrowtopready}, 64'd0);
        end
        chk("top_fifth", {40'd0, bitrowtop}, 64'h000001);
        for (int k = 1; k <= 58; k++) begin
            req(1'b0, 1'b0, 1'b1);
            chk("bot_ready", {63'd0, nextrowbotready}, 64'd1);
            chk("bot_data", {40'd0, bitrowbot}, {40'd0, bm[63 - k]});
        end
        chk("bot_58th", {40'd0, bitrowbot}, 64'h000001);
        for (int k = 1; k <= 23; k++) begin
            req(1'b1, 1'b0, 1'b0);
            chk("col_ready", {63'd0, nextcolumnready}, 64'd1);
            chk("col_data", bitcolumn, col_of(k));
        end
        chk("col23", bitcolumn, 64'h20);
        req(1'b1, 1'b0, 1'b0);
        chk("col_exhausted_ready", {63'd0, nextcolumnready}, 64'd0);
        chk("col_exhausted_hold", bitcolumn, 64'h20);
        cmpdone = 1'b1; cmpresult = 16'h0A5C;
        step();
        cmpdone = 1'b0;
        chk("result2", {48'd0, result}, 64'h0A5C);
        step();

        // Reset in the middle of a load.
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (30) step();
        chk("mid_load_addr", {58'd0, mem_addr}, 64'd30);
        rst = 1'b1;
        #1;
        chk("rst_mid_rd", {63'd0, mem_rd}, 64'd0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_result", {48'd0, result}, 64'd0);
        chk("rst_mid_data", {bitcolumn[15:0], bitrowtop, bitrowbot}, 64'd0);
        chk("rst_mid_col", bitcolumn, 64'd0);
        chk("rst_mid_pulses", {58'd0, mem_addr}, 64'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_quiet", {62'd0, busy, mem_rd}, 64'd0);
        end

        // Random bitmap with random request streams.
        for (int r = 0; r < 64; r++) bm[r] = 24'($urandom());
        load_and_check();
        mc = 0; mt = 0; mb = 63;
        for (int k = 0; k < 300; k++) begin
            nc = 1'($urandom_range(0, 1));
            nt = 1'($urandom_range(0, 1));
            nb = 1'($urandom_range(0, 1));
            ecr = nc && (mc < 23);
            etr = nt && (mt < 63);
            ebr = nb && (mb > 0);
            if (ecr) mc++;
            if (etr) mt++;
            if (ebr) mb--;
            req(nc, nt, nb);
            chk("rnd_ready", {61'd0, nextcolumnready, nextrowtopready, nextrowbotready},
                {61'd0, ecr, etr, ebr});
            chk("rnd_col", bitcolumn, col_of(mc));
            chk("rnd_top", {40'd0, bitrowtop}, {40'd0, bm[mt]});
            chk("rnd_bot", {40'd0, bitrowbot}, {40'd0, bm[mb]});
        end
        cmpresult = 16'($urandom());
        cmpdone = 1'b1;
        nc = 1'b0;
        step();
        cmpdone = 1'b0;
        chk("rnd_done", {63'd0, done}, 64'd1);
        chk("rnd_result", {48'd0, result}, {48'd0, cmpresult});
        step();
        chk("rnd_idle", {63'd0, busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
